wd_apb_mc: RTL and testbench
============================

WD_APB_MC -- requirements
Module: wd_apb_mc

Interface
REQ-001 Parameter NCH, default 4, number of watchdog channels, legal range 1..8.
REQ-002 Parameter DW, default 32, counter/start-value width, legal range 8..32.
REQ-003 Parameter RST_START, default all-ones (DW bits), reset value of every channel start value.
REQ-004 pclk  in  1  the single clock; all state changes on its rising edge.
REQ-005 prst_  in  1  reset, asynchronous, active-low.
REQ-006 psel, penable, pwrite  in  1 each  APB3 control signals.
REQ-007 paddr  in  8  byte address; pwdata  in  32  write data.
REQ-008 prdata  out  32  read data; pready  out  1  tied 1; pslverr  out  1  error response.
REQ-009 flag  out  NCH  per-channel feed-dog pulse.
REQ-010 update  out  NCH  per-channel pulse: load a new start value.
REQ-011 mode  out  2*NCH  channel c mode at bits [2c+1:2c].
REQ-012 start_value  out  DW*NCH  channel c start value at bits [DW*c+DW-1:DW*c].
REQ-013 timeout  in  NCH  per-channel expiry pulse from the counters.
REQ-014 irq  out  1  interrupt request, registered.

Function
REQ-015 Address map, channel c (c<NCH) base 16*c: +0x0 START (RW, DW LSBs), +0x4 FEED (WO), +0x8 MODE (RW, bits[1:0]), +0xC reserved.
REQ-016 Global registers: 0xF0 LOCK (RW, reads 0 locked, 1 unlocked), 0xF4 IRQ_STAT (NCH bits, read, write-1-to-clear), 0xF8 IRQ_EN (NCH bits, RW).
REQ-017 Any other address, including channel index >= NCH, is unmapped: writes ignored, reads return 0, pslverr=1 in the access phase.
REQ-018 Write commits on the cycle psel&penable&pwrite is high; no wait states.
REQ-019 Read data is registered on the setup-phase edge (psel&!penable&!pwrite) and held valid for the access phase.
REQ-020 pslverr is combinational, asserted only while psel&penable.
REQ-021 Lock FSM states LOCKED, KEY1, UNLOCKED; reset state LOCKED.
REQ-022 LOCKED: write 0x1ACCE551 to LOCK -> KEY1; any other write leaves LOCKED.
REQ-023 KEY1: the next APB write, if it is 0xE1E1E1E1 to LOCK -> UNLOCKED, otherwise -> LOCKED; that write has no other effect.
REQ-024 UNLOCKED: any write to LOCK -> LOCKED.
REQ-025 START and MODE writes take effect only in UNLOCKED; otherwise ignored with pslverr=1.
REQ-026 FEED, IRQ_STAT and IRQ_EN writes are never lock-protected.
REQ-027 A START write to channel c loads start_value[c] from pwdata[DW-1:0]; upper bits are discarded.
REQ-028 A START write also drives update[c] high for exactly one cycle, the cycle after the commit.
REQ-029 A FEED write (any data) to channel c drives flag[c] high for exactly one cycle, the cycle after the commit.
REQ-030 Back-to-back feeds produce back-to-back pulses.
REQ-031 timeout[c]=1 sets IRQ_STAT[c]; the bit is sticky.
REQ-032 When timeout[c] and a W1C of bit c occur in the same cycle, set wins.
REQ-033 irq is registered: irq = |(IRQ_STAT & IRQ_EN) from the previous cycle's register values.
REQ-034 Bits of START above DW, and MODE bits [31:2], read 0.

Reset
REQ-035 While prst_=0, and immediately on its assertion, all of the following hold:
- start_value = RST_START for every channel
- mode = 0, flag = 0, update = 0
- IRQ_STAT = 0, IRQ_EN = 0, irq = 0
- prdata = 0
- lock FSM in LOCKED
REQ-036 Reset asserted between the KEY1 write and the unlock write leaves the block LOCKED, and the unlock sequence must restart.

Verification
REQ-037 Write START ch1 = 0x100 while locked -> pslverr=1, start_value ch1 stays 0xFFFFFFFF, update=0.
REQ-038 Write LOCK 0x1ACCE551 then 0xE1E1E1E1, then START ch2 = 0x55 -> LOCK reads 1, update[2] high one cycle, START ch2 reads 0x55.
REQ-039 Write LOCK 0x1ACCE551, then FEED ch0, then LOCK 0xE1E1E1E1 -> flag[0] NOT pulsed, LOCK reads 0.
REQ-040 Write FEED ch3 on two consecutive transfers -> flag[3] pulses twice; flag for other channels stays 0.
REQ-041 IRQ_EN=0x1, timeout[0] pulse -> irq=1 one cycle later; W1C 0x1 coincident with a second timeout[0] -> IRQ_STAT[0] stays 1.
REQ-042 NCH=4, read paddr 0x40 -> prdata=0, pslverr=1.

Source files
------------

// File: rtl/wd_apb_mc_if.sv
// APB3 slave bus for the multi-channel watchdog register block.
interface wd_apb_mc_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (output psel, penable, pwrite, paddr, pwdata,
                    input  prdata, pready, pslverr);
    modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                    output prdata, pready, pslverr);
endinterface

// File: rtl/wd_apb_mc.sv
// APB3 control block for NCH watchdog channels: start/mode registers behind a
// two-key lock, feed pulses, sticky timeout status and a registered interrupt.
module wd_apb_mc #(
    parameter int          NCH       = 4,
    parameter int          DW        = 32,
    parameter logic [DW-1:0] RST_START = '1
) (
    input  logic              pclk,
    input  logic              prst_,
    wd_apb_mc_if.slave        apb,
    output logic [NCH-1:0]    flag,
    output logic [NCH-1:0]    update,
    output logic [2*NCH-1:0]  mode,
    output logic [DW*NCH-1:0] start_value,
    input  logic [NCH-1:0]    timeout,
    output logic              irq
);
    localparam logic [31:0] KEY1_VAL = 32'h1ACC_E551;
    localparam logic [31:0] KEY2_VAL = 32'hE1E1_E1E1;

    typedef enum logic [1:0] {LOCKED, KEY1, UNLOCKED} lock_t;

    lock_t                     r_state;
    logic [NCH-1:0][DW-1:0]    r_start;
    logic [NCH-1:0][1:0]       r_mode;
    logic [NCH-1:0]            r_flag, r_update, r_stat, r_en;
    logic                      r_irq;
    logic [31:0]               r_prdata;

    logic [3:0]  w_ch, w_off;
    logic        w_lock_a, w_stat_a, w_en_a, w_chm, w_prot, w_mapped, w_unl;
    logic        w_wr, w_rd_setup, w_eff;
    logic [NCH-1:0] w_w1c;
    logic [31:0] w_rdata;

    assign w_ch       = apb.paddr[7:4];
    assign w_off      = apb.paddr[3:0];
    assign w_lock_a   = apb.paddr == 8'hF0;
    assign w_stat_a   = apb.paddr == 8'hF4;
    assign w_en_a     = apb.paddr == 8'hF8;
    assign w_chm      = (32'(w_ch) < NCH) && (w_off == 4'h0 || w_off == 4'h4 || w_off == 4'h8);
    assign w_prot     = w_chm && (w_off != 4'h4);
    assign w_mapped   = w_lock_a || w_stat_a || w_en_a || w_chm;
    assign w_unl      = r_state == UNLOCKED;
    assign w_wr       = apb.psel && apb.penable && apb.pwrite;
    assign w_rd_setup = apb.psel && !apb.penable && !apb.pwrite;
    // The write that follows the first key is consumed by the lock sequence only.
    assign w_eff      = w_wr && (r_state != KEY1);
    assign w_w1c      = (w_eff && w_stat_a) ? apb.pwdata[NCH-1:0] : '0;

    assign apb.pready  = 1'b1;
    assign apb.pslverr = apb.psel && apb.penable &&
                         (!w_mapped || (apb.pwrite && w_prot && !w_unl));
    assign apb.prdata  = r_prdata;

    assign flag        = r_flag;
    assign update      = r_update;
    assign mode        = r_mode;
    assign start_value = r_start;
    assign irq         = r_irq;

    always_comb begin
        w_rdata = '0;
        if (w_lock_a)      w_rdata[0]       = w_unl;
        else if (w_stat_a) w_rdata[NCH-1:0] = r_stat;
        else if (w_en_a)   w_rdata[NCH-1:0] = r_en;
        else if (w_chm) begin
            for (int c = 0; c < NCH; c++) begin
                if (w_ch == 4'(c)) begin
                    if (w_off == 4'h0)      w_rdata[DW-1:0] = r_start[c];
                    else if (w_off == 4'h8) w_rdata[1:0]    = r_mode[c];
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge prst_) begin
        if (!prst_) begin
            r_state  <= LOCKED;
            r_start  <= {NCH{RST_START}};
            r_mode   <= '0;
            r_flag   <= '0;
            r_update <= '0;
            r_stat   <= '0;
            r_en     <= '0;
            r_irq    <= 1'b0;
            r_prdata <= '0;
        end else begin
            r_flag   <= '0;
            r_update <= '0;
            r_irq    <= |(r_stat & r_en);
            // Timeout is OR'd after the clear so a coincident set wins.
            r_stat   <= (r_stat & ~w_w1c) | timeout;
            if (w_rd_setup) r_prdata <= w_rdata;
            if (w_wr) begin
                case (r_state)
                    LOCKED:   if (w_lock_a && apb.pwdata == KEY1_VAL) r_state <= KEY1;
                    KEY1:     r_state <= (w_lock_a && apb.pwdata == KEY2_VAL) ? UNLOCKED : LOCKED;
                    UNLOCKED: if (w_lock_a) r_state <= LOCKED;
                    default:  r_state <= LOCKED;
                endcase
            end
            if (w_eff) begin
                if (w_en_a) r_en <= apb.pwdata[NCH-1:0];
                for (int c = 0; c < NCH; c++) begin
                    if (w_chm && w_ch == 4'(c)) begin
                        if (w_off == 4'h0 && w_unl) begin
                            r_start[c]  <= apb.pwdata[DW-1:0];
                            r_update[c] <= 1'b1;
                        end
                        if (w_off == 4'h4) r_flag[c] <= 1'b1;
                        if (w_off == 4'h8 && w_unl) r_mode[c] <= apb.pwdata[1:0];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_wd_apb_mc.sv
// Self-checking bench for wd_apb_mc: directed vector table, hand sequences for
// IRQ/W1C and reset-during-unlock, then random traffic against a register model.
module tb_wd_apb_mc;
    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam logic [31:0] K1 = 32'h1ACC_E551;
    localparam logic [31:0] K2 = 32'hE1E1_E1E1;

    logic pclk = 1'b0;
    logic prst_;
    logic [NCH-1:0]    flag, update, timeout;
    logic [2*NCH-1:0]  mode;
    logic [DW*NCH-1:0] start_value;
    logic              irq;

    wd_apb_mc_if bus();

    wd_apb_mc #(.NCH(NCH), .DW(DW)) dut (
        .pclk(pclk), .prst_(prst_), .apb(bus.slave),
        .flag(flag), .update(update), .mode(mode), .start_value(start_value),
        .timeout(timeout), .irq(irq));

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] tmo,
                          output logic e, output logic [3:0] fl, output logic [3:0] up);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = a; bus.pwdata = d;
        @(posedge pclk); #1;
        bus.penable = 1'b1; timeout = tmo;
        #1 e = bus.pslverr;
        @(posedge pclk); #1;
        fl = flag; up = update;
        bus.psel = 1'b0; bus.penable = 1'b0; timeout = '0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic e, output logic [31:0] d);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        #1 e = bus.pslverr; d = bus.prdata;
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    task automatic idle();
        @(posedge pclk); #1;
    endtask

    // Register-level model: what software would expect to observe.
    logic [NCH-1:0][31:0] m_start;
    logic [NCH-1:0][1:0]  m_mode;
    logic [3:0]           m_stat, m_en;
    bit                   m_unl, m_key;

    function automatic bit m_chmap(input logic [7:0] a);
        return (int'(a[7:4]) < NCH) && (a[3:0] == 4'h0 || a[3:0] == 4'h4 || a[3:0] == 4'h8);
    endfunction

    function automatic bit m_mapped(input logic [7:0] a);
        return m_chmap(a) || a == 8'hF0 || a == 8'hF4 || a == 8'hF8;
    endfunction

    function void m_reset();
        for (int c = 0; c < NCH; c++) begin m_start[c] = '1; m_mode[c] = '0; end
        m_stat = '0; m_en = '0; m_unl = 0; m_key = 0;
    endfunction

    function void m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] tmo,
                          output logic e, output logic [3:0] fl, output logic [3:0] up);
        int ch;
        logic [3:0] w1c;
        ch = int'(a[7:4]);
        e  = !m_mapped(a) || (m_chmap(a) && a[3:0] != 4'h4 && !m_unl);
        fl = '0; up = '0; w1c = '0;
        if (m_key) begin
            m_key = 0;
            m_unl = (a == 8'hF0 && d == K2);
        end else if (a == 8'hF0) begin
            if (m_unl) m_unl = 0;
            else if (d == K1) m_key = 1;
        end else if (a == 8'hF4) w1c = d[3:0];
        else if (a == 8'hF8) m_en = d[3:0];
        else if (m_chmap(a)) begin
            if (a[3:0] == 4'h0 && m_unl) begin m_start[ch] = d; up[ch] = 1'b1; end
            if (a[3:0] == 4'h4) fl[ch] = 1'b1;
            if (a[3:0] == 4'h8 && m_unl) m_mode[ch] = d[1:0];
        end
        m_stat = (m_stat & ~w1c) | tmo;
    endfunction

    function automatic void m_read(input logic [7:0] a, output logic e, output logic [31:0] d);
        e = !m_mapped(a);
        d = '0;
        if (a == 8'hF0)      d = {31'b0, m_unl};
        else if (a == 8'hF4) d = {28'b0, m_stat};
        else if (a == 8'hF8) d = {28'b0, m_en};
        else if (m_chmap(a) && a[3:0] == 4'h0) d = m_start[a[7:4]];
        else if (m_chmap(a) && a[3:0] == 4'h8) d = {30'b0, m_mode[a[7:4]]};
    endfunction

    typedef struct {
        bit          wr;
        logic [7:0]  a;
        logic [31:0] d;
        logic        err;
        logic [31:0] rd;
        logic [3:0]  fl;
        logic [3:0]  up;
    } vec_t;

    vec_t tbl[24];

    task automatic do_reset();
        prst_ = 1'b0;
        #1;
        chk("rst_flag", flag, 0);
        chk("rst_update", update, 0);
        chk("rst_mode", mode, 0);
        chk("rst_start", start_value, {NCH{32'hFFFF_FFFF}});
        chk("rst_irq", irq, 0);
        chk("rst_prdata", bus.prdata, 0);
        idle(); idle();
        prst_ = 1'b1;
        idle();
    endtask

    initial begin
        logic        e;
        logic [3:0]  fl, up, tmo;
        logic [31:0] rd, ed;
        logic        ee;
        logic [3:0]  efl, eup;
        logic [7:0]  a;
        logic [31:0] d;

        bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = '0; bus.pwdata = '0;
        timeout = '0; prst_ = 1'b1;
        #2;
        do_reset();

        tbl[0]  = '{1, 8'h10, 32'h100,      1, 0, 4'b0000, 4'b0000};
        tbl[1]  = '{0, 8'h10, 0,            0, 32'hFFFF_FFFF, 0, 0};
        tbl[2]  = '{0, 8'hF0, 0,            0, 0, 0, 0};
        tbl[3]  = '{1, 8'hF0, K1,           0, 0, 4'b0000, 4'b0000};
        tbl[4]  = '{1, 8'hF0, K2,           0, 0, 4'b0000, 4'b0000};
        tbl[5]  = '{0, 8'hF0, 0,            0, 1, 0, 0};
        tbl[6]  = '{1, 8'h20, 32'h55,       0, 0, 4'b0000, 4'b0100};
        tbl[7]  = '{0, 8'h20, 0,            0, 32'h55, 0, 0};
        tbl[8]  = '{1, 8'h28, 32'hFFFF_FFFF,0, 0, 4'b0000, 4'b0000};
        tbl[9]  = '{0, 8'h28, 0,            0, 3, 0, 0};
        tbl[10] = '{1, 8'hF0, 0,            0, 0, 4'b0000, 4'b0000};
        tbl[11] = '{0, 8'hF0, 0,            0, 0, 0, 0};
        tbl[12] = '{1, 8'hF0, K1,           0, 0, 4'b0000, 4'b0000};
        tbl[13] = '{1, 8'h04, 32'h1234,     0, 0, 4'b0000, 4'b0000};
        tbl[14] = '{1, 8'hF0, K2,           0, 0, 4'b0000, 4'b0000};
        tbl[15] = '{0, 8'hF0, 0,            0, 0, 0, 0};
        tbl[16] = '{1, 8'h34, 32'h0,        0, 0, 4'b1000, 4'b0000};
        tbl[17] = '{1, 8'h34, 32'hABCD,     0, 0, 4'b1000, 4'b0000};
        tbl[18] = '{0, 8'h40, 0,            1, 0, 0, 0};
        tbl[19] = '{1, 8'h40, 32'h77,       1, 0, 4'b0000, 4'b0000};
        tbl[20] = '{0, 8'h0C, 0,            1, 0, 0, 0};
        tbl[21] = '{1, 8'hF8, 32'h1F,       0, 0, 4'b0000, 4'b0000};
        tbl[22] = '{0, 8'hF8, 0,            0, 32'hF, 0, 0};
        tbl[23] = '{0, 8'h24, 0,            0, 0, 0, 0};

        for (int i = 0; i < 24; i++) begin
            if (tbl[i].wr) begin
                apb_wr(tbl[i].a, tbl[i].d, 4'b0, e, fl, up);
                chk($sformatf("vec%0d_err", i), e, tbl[i].err);
                chk($sformatf("vec%0d_flag", i), fl, tbl[i].fl);
                chk($sformatf("vec%0d_upd", i), up, tbl[i].up);
            end else begin
                apb_rd(tbl[i].a, e, rd);
                chk($sformatf("vec%0d_err", i), e, tbl[i].err);
                chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
            end
        end
        chk("out_start_ch1", start_value[32+:32], 32'hFFFF_FFFF);
        chk("out_start_ch2", start_value[64+:32], 32'h55);
        chk("out_mode_ch2", mode[5:4], 2'd3);
        idle();
        chk("flag_idle", flag, 0);

        // Interrupt path and set-beats-clear on IRQ_STAT.
        apb_wr(8'hF8, 32'h1, 4'b0, e, fl, up);
        apb_wr(8'hF4, 32'hF, 4'b0, e, fl, up);
        idle(); idle();
        chk("irq_before", irq, 0);
        timeout = 4'b0001;
        idle();
        timeout = '0;
        chk("irq_same_cycle", irq, 0);
        idle();
        chk("irq_next_cycle", irq, 1);
        apb_wr(8'hF4, 32'h1, 4'b0001, e, fl, up);
        apb_rd(8'hF4, e, rd);
        chk("stat_set_wins", rd, 32'h1);
        apb_wr(8'hF4, 32'h1, 4'b0, e, fl, up);
        apb_rd(8'hF4, e, rd);
        chk("stat_w1c", rd, 32'h0);
        idle();
        chk("irq_cleared", irq, 0);

        // Reset between the two keys must drop the half-done unlock.
        apb_wr(8'hF0, K1, 4'b0, e, fl, up);
        do_reset();
        apb_wr(8'hF0, K2, 4'b0, e, fl, up);
        apb_rd(8'hF0, e, rd);
        chk("lock_after_rst", rd, 0);
        apb_wr(8'hF0, K1, 4'b0, e, fl, up);
        apb_wr(8'hF0, K2, 4'b0, e, fl, up);
        apb_rd(8'hF0, e, rd);
        chk("unlock_restart", rd, 1);

        // Random traffic against the model, from a clean reset.
        do_reset();
        m_reset();
        for (int n = 0; n < 400; n++) begin
            int op;
            op = $urandom_range(0, 9);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = 8'(16 * $urandom_range(0, 5) + 4 * $urandom_range(0, 3));
                6: a = 8'hF0;
                7: a = 8'hF4;
                8: a = 8'hF8;
                default: a = 8'($urandom);
            endcase
            d = $urandom;
            if (a == 8'hF0 && $urandom_range(0, 2) != 0) d = $urandom_range(0, 1) ? K1 : K2;
            if (op < 5) begin
                tmo = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
                apb_wr(a, d, tmo, e, fl, up);
                m_write(a, d, tmo, ee, efl, eup);
                chk($sformatf("rnd%0d_wr_err", n), e, ee);
                chk($sformatf("rnd%0d_flag", n), fl, efl);
                chk($sformatf("rnd%0d_upd", n), up, eup);
            end else if (op < 8) begin
                apb_rd(a, e, rd);
                m_read(a, ee, ed);
                chk($sformatf("rnd%0d_rd_err", n), e, ee);
                chk($sformatf("rnd%0d_rdata", n), rd, ed);
            end else if (op == 8) begin
                tmo = 4'($urandom);
                timeout = tmo;
                idle();
                timeout = '0;
                m_stat = m_stat | tmo;
            end else begin
                apb_wr(8'hF0, K1, 4'b0, e, fl, up);
                m_write(8'hF0, K1, 4'b0, ee, efl, eup);
                apb_wr(8'hF0, K2, 4'b0, e, fl, up);
                m_write(8'hF0, K2, 4'b0, ee, efl, eup);
            end
            idle();
            chk($sformatf("rnd%0d_irq", n), irq, |(m_stat & m_en));
            chk($sformatf("rnd%0d_start", n), start_value, m_start);
            chk($sformatf("rnd%0d_mode", n), mode, m_mode);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
